// File: rtl/exec_pkg.sv
// Shared types and instruction field positions for the execute sequencer.
package exec_pkg;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SLTU = 4'd7,
        OP_MOV  = 4'd8
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: 8-bit result, carry/borrow and an illegal-opcode flag.
module alu_core
    import exec_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] y_o,
    output logic          carry_o,
    output logic          illegal_o
);

    logic [DW:0] sum;

    always_comb begin
        sum       = {1'b0, a_i} + {1'b0, b_i};
        y_o       = '0;
        carry_o   = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                y_o     = sum[DW-1:0];
                carry_o = sum[DW];
            end
            OP_SUB: begin
                y_o     = a_i - b_i;
                carry_o = (a_i < b_i);
            end
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SLL:  y_o = a_i << b_i[2:0];
            OP_SRL:  y_o = a_i >> b_i[2:0];
            OP_SLTU: y_o = DW'(a_i < b_i);
            OP_MOV:  y_o = a_i;
            // Undefined opcodes produce a zero result that is never written back.
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_seq.sv
// Serial execute sequencer: read operands, run the ALU, write back to the register file.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a new instruction; latch it on valid & ready
// READ    | drive rs1/rs2 addresses, capture operands at end of cycle
// EXEC    | ALU on captured operands, register result and flags
// WB      | pulse write (legal only) and done; illegal pulses illegal_o
module exec_seq
    import exec_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 3,
    parameter int IW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          instr_valid_i,
    output logic          instr_ready_o,
    input  logic [IW-1:0] instr_i,
    output logic [AW-1:0] rs1_addr_o,
    output logic [AW-1:0] rs2_addr_o,
    input  logic [DW-1:0] rs1_data_i,
    input  logic [DW-1:0] rs2_data_i,
    output logic          rd_wren_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [DW-1:0] rd_data_o,
    output logic          done_o,
    output logic          illegal_o,
    output logic          zero_o,
    output logic          carry_o
);

    state_e        state_q, state_d;
    logic [3:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs1_addr_q, rs2_addr_q;
    logic [DW-1:0] op_a_q, op_b_q, result_q;
    logic          zero_q, carry_q, illegal_q;
    logic          accept;

    logic [DW-1:0] alu_y;
    logic          alu_carry, alu_illegal;

    // Reserved low instruction bits carry no meaning.
    logic          unused_instr;
    assign unused_instr = ^instr_i[RS2_LSB-1:0];

    alu_core #(.DW(DW)) u_alu (
        .op_i      (op_q),
        .a_i       (op_a_q),
        .b_i       (op_b_q),
        .y_o       (alu_y),
        .carry_o   (alu_carry),
        .illegal_o (alu_illegal)
    );

    assign accept = instr_valid_i && (state_q == ST_IDLE);

    always_comb begin
        state_d       = state_q;
        instr_ready_o = 1'b0;
        rd_wren_o     = 1'b0;
        rd_addr_o     = '0;
        rd_data_o     = '0;
        done_o        = 1'b0;
        illegal_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) state_d = ST_READ;
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                rd_wren_o = !illegal_q;
                rd_addr_o = rd_q;
                rd_data_o = result_q;
                done_o    = 1'b1;
                illegal_o = illegal_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Read addresses are loaded at accept so they are valid for all of READ and hold afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q       <= '0;
            rd_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
        end else if (accept) begin
            op_q       <= instr_i[OP_MSB:OP_LSB];
            rd_q       <= instr_i[RD_MSB:RD_LSB];
            rs1_addr_q <= instr_i[RS1_MSB:RS1_LSB];
            rs2_addr_q <= instr_i[RS2_MSB:RS2_LSB];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (state_q == ST_READ) begin
            op_a_q <= rs1_data_i;
            op_b_q <= rs2_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q  <= '0;
            illegal_q <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            result_q  <= alu_y;
            illegal_q <= alu_illegal;
            // Flags survive an illegal instruction untouched.
            if (!alu_illegal) begin
                zero_q  <= (alu_y == '0);
                carry_q <= alu_carry;
            end
        end
    end

    assign rs1_addr_o = rs1_addr_q;
    assign rs2_addr_o = rs2_addr_q;
    assign zero_o     = zero_q;
    assign carry_o    = carry_q;

endmodule

// File: tb/tb_exec_seq.sv
// Directed bench for exec_seq with a behavioural 8x8 register file and a write-back scoreboard.
module tb_exec_seq;

    typedef struct {
        logic       wren;
        logic       ill;
        logic [2:0] addr;
        logic [7:0] data;
        logic       z;
        logic       c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  rs1_addr, rs2_addr, rd_addr;
    logic [7:0]  rs1_data, rs2_data, rd_data;
    logic        rd_wren, done, illegal, zero, carry;

    logic [7:0]  rf [8];
    logic        rf_clr, bd_we;
    logic [2:0]  bd_addr;
    logic [7:0]  bd_data;

    exp_t        exp_q [$];
    int          cyc_q [$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          prev_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exec_seq u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .instr_i       (instr),
        .rs1_addr_o    (rs1_addr),
        .rs2_addr_o    (rs2_addr),
        .rs1_data_i    (rs1_data),
        .rs2_data_i    (rs2_data),
        .rd_wren_o     (rd_wren),
        .rd_addr_o     (rd_addr),
        .rd_data_o     (rd_data),
        .done_o        (done),
        .illegal_o     (illegal),
        .zero_o        (zero),
        .carry_o       (carry)
    );

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'd0;
        end else if (rd_wren) begin
            rf[rd_addr] <= rd_data;
        end else if (bd_we) begin
            rf[bd_addr] <= bd_data;
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic w, input logic il, input logic [2:0] a,
                                input logic [7:0] d, input logic z, input logic c);
        exp_t e;
        e.wren = w; e.ill = il; e.addr = a; e.data = d; e.z = z; e.c = c;
        return e;
    endfunction

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
        logic [3:0] o;
        logic [2:0] d, s1, s2;
        o = 4'(op); d = 3'(rd); s1 = 3'(rs1); s2 = 3'(rs2);
        return {o, d, s1, s2, 3'b101};
    endfunction

    // Monitor: every write-back cycle is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_wren && !done) chk("wren_without_done", 1, 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    int   ec;
                    e  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    chk("wb_cycle", cyc, ec);
                    chk("rd_wren", int'(rd_wren), int'(e.wren));
                    chk("illegal", int'(illegal), int'(e.ill));
                    chk("zero_flag", int'(zero), int'(e.z));
                    chk("carry_flag", int'(carry), int'(e.c));
                    if (e.wren) begin
                        chk("rd_addr", int'(rd_addr), int'(e.addr));
                        chk("rd_data", int'(rd_data), int'(e.data));
                    end
                end
            end
        end
    end

    task automatic backdoor(input int a, input int d);
        bd_we = 1'b1; bd_addr = 3'(a); bd_data = 8'(d);
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [15:0] ins, input exp_t e, input bit push,
                         input bit keep, input bit gap4);
        int w;
        instr_valid = 1'b1;
        instr       = ins;
        w = 0;
        while (!instr_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (gap4) chk("accept_gap", cyc - prev_acc, 4);
        prev_acc = cyc;
        if (push) begin
            exp_q.push_back(e);
            cyc_q.push_back(cyc + 2);
        end
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(instr_ready), 1);
        chk({tag, "_wren"}, int'(rd_wren), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_illegal"}, int'(illegal), 0);
        chk({tag, "_zero"}, int'(zero), 0);
        chk({tag, "_carry"}, int'(carry), 0);
        chk({tag, "_rs1_addr"}, int'(rs1_addr), 0);
        chk({tag, "_rs2_addr"}, int'(rs2_addr), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_rd_data"}, int'(rd_data), 0);
    endtask

    initial begin
        exp_t dummy;
        int   w;
        logic [7:0] final_rf [8];
        dummy = mk(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0;
        rf_clr = 1'b1; bd_we = 1'b0; bd_addr = 3'd0; bd_data = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1; rf_clr = 1'b0;
        @(negedge clk);

        issue(enc(0, 2, 0, 0), mk(1, 0, 2, 8'd0, 1, 0), 1, 0, 0);
        repeat (4) @(negedge clk);
        chk("r2_after_add0", int'(rf[2]), 0);

        backdoor(1, 200);
        backdoor(2, 3);
        backdoor(3, 100);

        issue(enc(8, 5, 1, 0), mk(1, 0, 5, 8'd200, 0, 0), 1, 0, 0);
        issue(enc(0, 4, 1, 3), mk(1, 0, 4, 8'd44,  0, 1), 1, 0, 0);
        issue(enc(1, 5, 3, 1), mk(1, 0, 5, 8'd156, 0, 1), 1, 0, 0);
        issue(enc(12, 5, 1, 3), mk(0, 1, 5, 8'd0,  0, 1), 1, 0, 0);
        issue(enc(2, 6, 1, 3), mk(1, 0, 6, 8'd64,  0, 0), 1, 0, 0);
        issue(enc(5, 7, 3, 2), mk(1, 0, 7, 8'd32,  0, 0), 1, 0, 0);
        issue(enc(6, 7, 1, 2), mk(1, 0, 7, 8'd25,  0, 0), 1, 0, 0);
        issue(enc(7, 6, 3, 1), mk(1, 0, 6, 8'd1,   0, 0), 1, 0, 0);
        issue(enc(4, 4, 1, 1), mk(1, 0, 4, 8'd0,   1, 0), 1, 0, 0);
        issue(enc(15, 7, 1, 3), mk(0, 1, 7, 8'd0,  1, 0), 1, 0, 0);
        issue(enc(3, 0, 1, 3), mk(1, 0, 0, 8'd236, 0, 0), 1, 0, 0);
        issue(enc(0, 1, 1, 1), mk(1, 0, 1, 8'd144, 0, 1), 1, 0, 0);

        // Valid held across three back-to-back instructions.
        issue(enc(1, 3, 1, 0), mk(1, 0, 3, 8'd164, 0, 1), 1, 1, 0);
        issue(enc(8, 4, 3, 0), mk(1, 0, 4, 8'd164, 0, 0), 1, 1, 1);
        issue(enc(7, 2, 0, 1), mk(1, 0, 2, 8'd0,   1, 0), 1, 0, 1);

        // Abort during EXEC: no write-back, outputs back to reset values.
        issue(enc(0, 6, 1, 1), dummy, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("r6_after_abort", int'(rf[6]), 1);

        issue(enc(0, 2, 1, 3), mk(1, 0, 2, 8'd52, 0, 1), 1, 0, 0);

        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        @(negedge clk);

        final_rf[0] = 8'd236; final_rf[1] = 8'd144; final_rf[2] = 8'd52;  final_rf[3] = 8'd164;
        final_rf[4] = 8'd164; final_rf[5] = 8'd156; final_rf[6] = 8'd1;   final_rf[7] = 8'd25;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("final_r%0d", i), int'(rf[i]), int'(final_rf[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
